// File: rtl/mul_div_unit_if.sv
// Bus between the pipeline and the multi-cycle multiply/divide unit.
// master = pipeline side, slave = mul_div_unit.
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    // Handshake: start is a one-cycle request honoured only on an edge where busy=0;
    // busy is the not-ready indication, done is a one-cycle valid for hi/lo/div_zero.
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] num1;
    logic [WIDTH-1:0] num2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_zero;
    logic [1:0]       state_dbg;

    modport master (
        output start, op, num1, num2,
        input  busy, done, hi, lo, div_zero, state_dbg
    );

    modport slave (
        input  start, op, num1, num2,
        output busy, done, hi, lo, div_zero, state_dbg
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative 32-bit MULT/MULTU (shift-add) and DIV/DIVU (restoring) unit writing HI/LO.
// Optional macro MULDIV_EARLY_ZERO_EN: zero-operand ops bypass the iteration phase.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    mul_div_unit_if.slave        bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;     // upper product half / partial remainder
    logic [WIDTH-1:0] mq_q, mq_d;       // multiplier / dividend-then-quotient
    logic [WIDTH-1:0] dvs_q, dvs_d;     // multiplicand / divisor magnitude
    logic [WIDTH-1:0] raw1_q, raw1_d;
    logic             is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             zdiv_q, zdiv_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;
`ifdef MULDIV_EARLY_ZERO_EN
    logic             early_q, early_d;
`endif

    logic             sign1, sign2;
    logic [WIDTH-1:0] mag1, mag2;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] trial;
    logic             div_borrow;
    logic             trial_unused;
    logic [2*WIDTH-1:0] prod;

    assign sign1 = ~bus.op[0] & bus.num1[WIDTH-1];
    assign sign2 = ~bus.op[0] & bus.num2[WIDTH-1];
    assign mag1  = sign1 ? -bus.num1 : bus.num1;
    assign mag2  = sign2 ? -bus.num2 : bus.num2;

    assign mul_sum      = {1'b0, acc_q} + (mq_q[0] ? {1'b0, dvs_q} : '0);
    assign rem_sh       = {acc_q, mq_q[WIDTH-1]};
    assign trial        = {1'b0, rem_sh} - {2'b00, dvs_q};
    assign div_borrow   = trial[WIDTH+1];
    // A successful trial is always below the divisor, so this bit is zero whenever used.
    assign trial_unused = trial[WIDTH];
    assign prod         = {acc_q, mq_q};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        dvs_d     = dvs_q;
        raw1_d    = raw1_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        zdiv_d    = zdiv_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dz_d      = dz_q;
`ifdef MULDIV_EARLY_ZERO_EN
        early_d   = early_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    is_div_d  = bus.op[1];
                    neg_res_d = sign1 ^ sign2;
                    neg_rem_d = sign1;
                    raw1_d    = bus.num1;
                    zdiv_d    = bus.op[1] & (bus.num2 == '0);
                    acc_d     = '0;
                    mq_d      = bus.op[1] ? mag1 : mag2;
                    dvs_d     = bus.op[1] ? mag2 : mag1;
                    cnt_d     = '0;
`ifdef MULDIV_EARLY_ZERO_EN
                    early_d   = (bus.num1 == '0) | (~bus.op[1] & (bus.num2 == '0));
                    state_d   = early_d ? FIX : CALC;
`else
                    state_d   = CALC;
`endif
                end
            end
            CALC: begin
                if (is_div_q) begin
                    if (!div_borrow) begin
                        acc_d = trial[WIDTH-1:0];
                        mq_d  = {mq_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = rem_sh[WIDTH-1:0];
                        mq_d  = {mq_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = mul_sum[WIDTH:1];
                    mq_d  = {mul_sum[0], mq_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                dz_d    = zdiv_q;
                if (zdiv_q) begin
                    hi_d = raw1_q;
                    lo_d = '1;
`ifdef MULDIV_EARLY_ZERO_EN
                end else if (early_q) begin
                    hi_d = '0;
                    lo_d = '0;
`endif
                end else if (is_div_q) begin
                    hi_d = neg_rem_q ? -acc_q : acc_q;
                    lo_d = neg_res_q ? -mq_q : mq_q;
                end else begin
                    {hi_d, lo_d} = neg_res_q ? -prod : prod;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mq_q      <= '0;
            dvs_q     <= '0;
            raw1_q    <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            zdiv_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
`ifdef MULDIV_EARLY_ZERO_EN
            early_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            dvs_q     <= dvs_d;
            raw1_q    <= raw1_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            zdiv_q    <= zdiv_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
`ifdef MULDIV_EARLY_ZERO_EN
            early_q   <= early_d;
`endif
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.div_zero  = dz_q;
    assign bus.state_dbg = state_q;
endmodule
